id_queue: RTL and testbench
===========================

// Module: id_queue
// PURPOSE
//  Parametrised fetch-to-decode instruction queue; replaces the single-slot IF/ID latch.
//  Buffers up to IN_W fetched instructions per cycle (inst, pc, fetch addr error).
//  Presents up to ISSUE_W in-order instructions per cycle to the decoders.
//  Predecodes branches so a branch and its delay slot always leave in the same cycle (ISSUE_W>=2).
// PARAMETERS
//  DEPTH    8  entries; power of 2, >= 2*max(IN_W,ISSUE_W)
//  IN_W     2  max instructions enqueued per cycle (1..2)
//  ISSUE_W  2  max instructions presented per cycle (1..2)
//  PTR_W    $clog2(DEPTH)  localparam, not overridable
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous reset, active high
//  flush          in   1          sync clear (exception/eret/mispredict redirect)
//  in_valid       in   IN_W       per-slot valid, contiguous from bit 0
//  in_inst        in   32*IN_W    slot i at [32i+31:32i]
//  in_pc          in   32*IN_W    pc of slot i
//  in_addr_error  in   IN_W       fetch address error of slot i
//  in_ready       out  1          free entries >= IN_W
//  out_valid      out  ISSUE_W    presented slots, contiguous from bit 0
//  out_inst       out  32*ISSUE_W instruction, slot 0 = oldest
//  out_pc         out  32*ISSUE_W pc
//  out_addr_error out  ISSUE_W    fetch address error
//  out_is_branch  out  ISSUE_W    predecoded branch/jump
//  out_ds         out  ISSUE_W    slot is a delay slot
//  issue_cnt      in   2          slots consumed this cycle, <= popcount(out_valid)
//  count          out  PTR_W+1    occupied entries
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, last_br=0; out_valid=0, in_ready=1, all out_* data 0.
//  - Enqueue: if in_ready, write popcount(in_valid) entries at tail, slot 0 first; tail+=n mod DEPTH.
//    Non-contiguous in_valid (e.g. 2'b10) is illegal; assertion fires.
//  - Each entry stores is_branch (predecode) and ds = is_branch of the previously enqueued
//    instr; last_br register carries this across enqueue cycles.
//  - Dequeue: head += issue_cnt mod DEPTH. Enq+deq same cycle: count += n - issue_cnt.
//    issue_cnt > popcount(out_valid) is illegal; assertion fires.
//  - Presentation (combinational from storage): slot i eligible if count > i and slot i-1 valid.
//    ISSUE_W>=2: branch in slot i valid only if i+1<ISSUE_W and count>i+1 (DS present);
//    otherwise withheld, along with all younger slots. ISSUE_W==1: branches issue alone.
//  - Full: in_ready=0, in_valid ignored, no state change. Empty: out_valid=0.
//  - Pointer wrap: modulo DEPTH; count distinguishes full from empty.
//  - flush: next cycle head=tail=count=0, last_br=0; overrides same-cycle enq/deq.
//  - rst mid-operation: all state cleared immediately; partial enqueue discarded.
//  - Latency: enqueue to out_valid = 1 cycle (without bypass).
// CONFIGURATION
//  IDQ_BYPASS_EN defined: when count==0 and !flush, incoming slots are presented the
//    same cycle (0-cycle latency); slots consumed by issue_cnt are not written, rest are
//    written at tail. Branch/DS pairing applies to bypassed slots identically.
//  Undefined: no bypass, out_* driven only from storage, latency 1 cycle.
// STRUCTURE
//  - head.vh: `OP_SPEC, `OP_REGIMM, `FUNC_JR, `FUNC_JALR, opcode range 2..7 for j/jal/beq/bne/blez/bgtz.
//  - Sub-module idq_predecode (combinational, inst -> is_branch), instantiated IN_W times.
//  - Storage: flat regs inst/pc/aerr/br/ds[DEPTH]; no RAM macro.
// TESTING
//  - Reset then enq {addu,addu} pc 0x1000/0x1004, issue_cnt=2 next cycle -> out_valid=2'b11, count 2->0.
//  - Enq {beq, nop} at 0x2000 -> next cycle out_valid=2'b11, out_is_branch=2'b01, out_ds=2'b10.
//  - Enq {addu, jr} then later {nop} -> first presents 2'b01 (jr withheld); after nop enq,
//    slot0=jr, slot1=nop, out_ds=2'b10.
//  - Fill DEPTH=8 with 4x2 enq, no issue -> in_ready=0, count=8; then issue 2 -> in_ready=1, wrap to head 0x2.
//  - count=5, flush with simultaneous enq and issue_cnt=2 -> next cycle count=0, out_valid=0, last_br=0.
//  - IDQ_BYPASS_EN, empty, enq {ori, ori} with issue_cnt=1 same cycle -> out_valid=2'b11, count=1 after.

Source files
------------

// File: rtl/id_queue_pkg.sv
// id_queue_pkg: shared types and MIPS opcode constants for the fetch-to-decode instruction queue
package id_queue_pkg;

    localparam logic [5:0] OP_SPEC   = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BR_LO  = 6'h02;
    localparam logic [5:0] OP_BR_HI  = 6'h07;
    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_JALR = 6'h09;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        aerr;
        logic        br;
        logic        ds;
    } entry_t;

    // j/jal/beq/bne/blez/bgtz, every REGIMM branch, and register jumps jr/jalr
    function automatic logic branch_op(input logic [5:0] op, input logic [5:0] func);
        return (op >= OP_BR_LO && op <= OP_BR_HI) || op == OP_REGIMM ||
               (op == OP_SPEC && (func == FUNC_JR || func == FUNC_JALR));
    endfunction

endpackage

// File: rtl/idq_predecode.sv
// idq_predecode: combinational branch/jump predecode of one fetched instruction
module idq_predecode
    import id_queue_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_branch
);

    logic unused_bits;

    assign is_branch   = branch_op(inst[31:26], inst[5:0]);
    assign unused_bits = ^inst[25:6];

endmodule

// File: rtl/id_queue.sv
// id_queue: multi-slot fetch-to-decode instruction queue with branch/delay-slot pairing
// Optional macro IDQ_BYPASS_EN: present incoming slots in the same cycle when the queue is empty.
module id_queue
    import id_queue_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter int  IN_W    = 2,
    parameter int  ISSUE_W = 2,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [IN_W-1:0]       in_valid,
    input  logic [32*IN_W-1:0]    in_inst,
    input  logic [32*IN_W-1:0]    in_pc,
    input  logic [IN_W-1:0]       in_addr_error,
    output logic                  in_ready,
    output logic [ISSUE_W-1:0]    out_valid,
    output logic [32*ISSUE_W-1:0] out_inst,
    output logic [32*ISSUE_W-1:0] out_pc,
    output logic [ISSUE_W-1:0]    out_addr_error,
    output logic [ISSUE_W-1:0]    out_is_branch,
    output logic [ISSUE_W-1:0]    out_ds,
    input  logic [1:0]            issue_cnt,
    output logic [PTR_W:0]        count
);

    localparam int CW = PTR_W + 1;

    entry_t           mem [DEPTH];
    entry_t           in_e [IN_W];
    entry_t           v_e [ISSUE_W];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             last_br;
    logic             lb_next;
    logic [IN_W-1:0]  in_br;
    logic [IN_W:0]    br_chain;
    logic [CW-1:0]    enq_n;
    logic [CW-1:0]    avail;
    logic [1:0]       valid_n;
    logic             byp;

    for (genvar i = 0; i < IN_W; i++) begin : g_pd
        idq_predecode u_pd (
            .inst      (in_inst[32*i +: 32]),
            .is_branch (in_br[i])
        );
    end

    // Each slot's delay-slot tag is the branch flag of the instruction enqueued just before it
    assign br_chain = {in_br, last_br};
    assign in_ready = (CW'(DEPTH) - count) >= CW'(IN_W);

    // Build incoming entries, count accepted slots and track the newest accepted branch flag
    always_comb begin
        enq_n   = '0;
        lb_next = last_br;
        for (int i = 0; i < IN_W; i++) begin
            in_e[i].inst = in_inst[32*i +: 32];
            in_e[i].pc   = in_pc[32*i +: 32];
            in_e[i].aerr = in_addr_error[i];
            in_e[i].br   = in_br[i];
            in_e[i].ds   = br_chain[i];
            if (in_ready && in_valid[i]) begin
                enq_n   = enq_n + CW'(1);
                lb_next = in_br[i];
            end
        end
    end

    // Present the oldest slots in order; a branch is held back until its delay slot can go with it
    always_comb begin
        logic stop;
`ifdef IDQ_BYPASS_EN
        byp = (count == '0) && !flush;
`else
        byp = 1'b0;
`endif
        avail          = byp ? enq_n : count;
        stop           = 1'b0;
        valid_n        = '0;
        out_valid      = '0;
        out_inst       = '0;
        out_pc         = '0;
        out_addr_error = '0;
        out_is_branch  = '0;
        out_ds         = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            v_e[i] = (byp && i < IN_W) ? in_e[(i < IN_W) ? i : 0] : mem[head + PTR_W'(i)];
            stop = stop || avail <= CW'(i) ||
                   (v_e[i].br && ISSUE_W > 1 && (i + 1 >= ISSUE_W || avail <= CW'(i + 1)));
            if (!stop) begin
                out_valid[i]          = 1'b1;
                out_inst[32*i +: 32]  = v_e[i].inst;
                out_pc[32*i +: 32]    = v_e[i].pc;
                out_addr_error[i]     = v_e[i].aerr;
                out_is_branch[i]      = v_e[i].br;
                out_ds[i]             = v_e[i].ds;
                valid_n               = valid_n + 2'd1;
            end
        end
    end

    // Pointers, occupancy and branch history; flush wipes them and wins over enqueue/dequeue
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            last_br <= 1'b0;
        end else begin
            head    <= head + PTR_W'(issue_cnt);
            tail    <= tail + PTR_W'(enq_n);
            count   <= count + enq_n - CW'(issue_cnt);
            last_br <= lb_next;
        end
    end

    // Storage: accepted slots are written at tail in slot order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < IN_W; i++)
                if (CW'(i) < enq_n) mem[tail + PTR_W'(i)] <= in_e[i];
        end
    end

    // Slot valids must be contiguous from slot 0, and issue can never exceed what is presented
    a_in_contig: assert property (@(posedge clk) disable iff (rst)
        (in_valid & (in_valid + IN_W'(1))) == '0);
    a_issue_cnt: assert property (@(posedge clk) disable iff (rst)
        issue_cnt <= valid_n);

endmodule

// File: tb/tb_id_queue.sv
// tb_id_queue: directed self-checking bench for id_queue (default build; bypass scenario under IDQ_BYPASS_EN)
module tb_id_queue;

    localparam logic [31:0] ADDU = 32'h00430821;
    localparam logic [31:0] NOP  = 32'h00000000;
    localparam logic [31:0] BEQ  = 32'h10220004;
    localparam logic [31:0] JR   = 32'h03E00008;
`ifdef IDQ_BYPASS_EN
    localparam logic [31:0] ORI  = 32'h34010001;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic [1:0]  in_addr_error;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [1:0]  out_addr_error;
    logic [1:0]  out_is_branch;
    logic [1:0]  out_ds;
    logic [1:0]  issue_cnt;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    id_queue #(.DEPTH(8), .IN_W(2), .ISSUE_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_addr_error  (in_addr_error),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_addr_error (out_addr_error),
        .out_is_branch  (out_is_branch),
        .out_ds         (out_ds),
        .issue_cnt      (issue_cnt),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1);
        in_valid      = v;
        in_inst       = {i1, i0};
        in_pc         = {p1, p0};
        in_addr_error = 2'b00;
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        issue_cnt = 2'd0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_inst !== 64'h0 || out_pc !== 64'h0) begin errors++; $display("FAIL reset_data got inst=%h pc=%h exp=0", out_inst, out_pc); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        drive(2'b11, ADDU, 32'h1000, ADDU, 32'h1004);
        #1;
`ifndef IDQ_BYPASS_EN
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL basic_latency got=%b exp=00", out_valid); end
`endif
        tick();
        idle();
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL basic_count got=%0d exp=2", count); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got=%b exp=11", out_valid); end
        checks++; if (out_pc !== {32'h1004, 32'h1000}) begin errors++; $display("FAIL basic_pc got=%h exp=%h", out_pc, {32'h1004, 32'h1000}); end
        checks++; if (out_inst !== {ADDU, ADDU} || out_is_branch !== 2'b00) begin errors++; $display("FAIL basic_inst got=%h br=%b exp=%h br=00", out_inst, out_is_branch, {ADDU, ADDU}); end
        issue_cnt = 2'd2;
        tick();
        issue_cnt = 2'd0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_drain_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL basic_drain_valid got=%b exp=00", out_valid); end
    endtask

    task automatic test_branch_pair();
        drive(2'b11, BEQ, 32'h2000, NOP, 32'h2004);
        in_addr_error = 2'b10;
        tick();
        idle();
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL beq_valid got=%b exp=11", out_valid); end
        checks++; if (out_is_branch !== 2'b01) begin errors++; $display("FAIL beq_is_branch got=%b exp=01", out_is_branch); end
        checks++; if (out_ds !== 2'b10) begin errors++; $display("FAIL beq_ds got=%b exp=10", out_ds); end
        checks++; if (out_addr_error !== 2'b10) begin errors++; $display("FAIL beq_aerr got=%b exp=10", out_addr_error); end
        checks++; if (out_inst !== {NOP, BEQ}) begin errors++; $display("FAIL beq_inst got=%h exp=%h", out_inst, {NOP, BEQ}); end
        issue_cnt = 2'd2;
        tick();
        issue_cnt = 2'd0;
    endtask

    task automatic test_withheld();
        drive(2'b11, ADDU, 32'h3000, JR, 32'h3004);
        tick();
        idle();
        checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL jr_held_valid got=%b exp=01", out_valid); end
        checks++; if (out_pc[31:0] !== 32'h3000) begin errors++; $display("FAIL jr_held_pc got=%h exp=3000", out_pc[31:0]); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL jr_held_count got=%0d exp=2", count); end
        issue_cnt = 2'd1;
        tick();
        issue_cnt = 2'd0;
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL jr_alone_valid got=%b exp=00", out_valid); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL jr_alone_count got=%0d exp=1", count); end
        drive(2'b01, NOP, 32'h3008, 32'h0, 32'h0);
        tick();
        idle();
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL jr_pair_valid got=%b exp=11", out_valid); end
        checks++; if (out_inst !== {NOP, JR}) begin errors++; $display("FAIL jr_pair_inst got=%h exp=%h", out_inst, {NOP, JR}); end
        checks++; if (out_is_branch !== 2'b01) begin errors++; $display("FAIL jr_pair_is_branch got=%b exp=01", out_is_branch); end
        checks++; if (out_ds !== 2'b10) begin errors++; $display("FAIL jr_pair_ds got=%b exp=10", out_ds); end
        checks++; if (out_pc !== {32'h3008, 32'h3004}) begin errors++; $display("FAIL jr_pair_pc got=%h exp=%h", out_pc, {32'h3008, 32'h3004}); end
        issue_cnt = 2'd2;
        tick();
        issue_cnt = 2'd0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL jr_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_rst_mid();
        drive(2'b11, ADDU, 32'h9000, ADDU, 32'h9004);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_valid got=%b exp=00", out_valid); end
        tick();
        rst = 1'b0;
        idle();
        tick();
        checks++; if (count !== 4'd0 || out_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_discard got count=%0d valid=%b exp=0/00", count, out_valid); end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, ADDU, 32'h4000 + 32'(8*k), ADDU, 32'h4004 + 32'(8*k));
            tick();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        drive(2'b11, ADDU, 32'h5000, ADDU, 32'h5004);
        tick();
        idle();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_ignore_count got=%0d exp=8", count); end
        checks++; if (out_pc !== {32'h4004, 32'h4000}) begin errors++; $display("FAIL full_ignore_pc got=%h exp=%h", out_pc, {32'h4004, 32'h4000}); end
        issue_cnt = 2'd2;
        tick();
        issue_cnt = 2'd0;
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL drain2_count got=%0d exp=6", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain2_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_pc !== {32'h400C, 32'h4008}) begin errors++; $display("FAIL drain2_pc got=%h exp=%h", out_pc, {32'h400C, 32'h4008}); end
        drive(2'b11, ADDU, 32'h4020, ADDU, 32'h4024);
        tick();
        idle();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_enq_count got=%0d exp=8", count); end
        issue_cnt = 2'd2;
        repeat (3) tick();
        issue_cnt = 2'd0;
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", count); end
        checks++; if (out_pc !== {32'h4024, 32'h4020}) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", out_pc, {32'h4024, 32'h4020}); end
    endtask

    task automatic test_flush();
        drive(2'b11, ADDU, 32'h6000, ADDU, 32'h6004);
        tick();
        drive(2'b01, BEQ, 32'h6008, 32'h0, 32'h0);
        tick();
        idle();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_flush_count got=%0d exp=5", count); end
        flush = 1'b1;
        drive(2'b11, ADDU, 32'h7000, ADDU, 32'h7004);
        issue_cnt = 2'd2;
        tick();
        idle();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        drive(2'b11, NOP, 32'h8000, NOP, 32'h8004);
        tick();
        idle();
        checks++; if (out_ds !== 2'b00) begin errors++; $display("FAIL flush_last_br got ds=%b exp=00", out_ds); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL post_flush_valid got=%b exp=11", out_valid); end
        checks++; if (out_pc !== {32'h8004, 32'h8000}) begin errors++; $display("FAIL post_flush_pc got=%h exp=%h", out_pc, {32'h8004, 32'h8000}); end
        issue_cnt = 2'd2;
        tick();
        issue_cnt = 2'd0;
    endtask

`ifdef IDQ_BYPASS_EN
    task automatic test_bypass();
        drive(2'b11, ORI, 32'hA000, ORI, 32'hA004);
        issue_cnt = 2'd1;
        #1;
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL bypass_valid got=%b exp=11", out_valid); end
        checks++; if (out_pc[31:0] !== 32'hA000) begin errors++; $display("FAIL bypass_pc got=%h exp=a000", out_pc[31:0]); end
        tick();
        idle();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL bypass_count got=%0d exp=1", count); end
        checks++; if (out_valid !== 2'b01 || out_pc[31:0] !== 32'hA004) begin errors++; $display("FAIL bypass_rest got valid=%b pc=%h exp=01/a004", out_valid, out_pc[31:0]); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_branch_pair();
        test_withheld();
        test_rst_mid();
        test_full_wrap();
        test_flush();
`ifdef IDQ_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
